sram_arbiter: RTL

Shares the single-port synchronous data SRAM between the instruction-fetch requester and the load/store requester of the pipeline. The EX stage issues data accesses and the IF stage issues instruction fetches. The arbiter grants at most one request per cycle and drives the SRAM port. It returns each response one cycle later on the owning requester's `*_data_ok` and `*_rdata`. Data requests have priority, and a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/sram_arbiter_if.sv | 42 ++++
 rtl/sram_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the data SRAM.
// The slave modport is the arbiter's view; master is everything around it.
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port data SRAM arbiter: data accesses win, instruction fetch is protected from
// starvation by a saturating counter; responses return one cycle after the grant.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic          clk,
  input logic          reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INST    = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  owner_t     owner_reg, owner_next;
  logic [2:0] starve_cnt_reg, starve_cnt_next;
  logic       grant_d, grant_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= 3'd0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    grant_d         = 1'b0;
    grant_i         = 1'b0;
    owner_next      = OWN_NONE;
    starve_cnt_next = starve_cnt_reg;

    // Grants are held low during reset so nothing reaches the SRAM.
    if (reset) begin
      grant_d = bus.data_req && !(bus.inst_req && (starve_cnt_reg == STARVE_LIM));
      grant_i = bus.inst_req && !grant_d;
    end

    if (grant_d) begin
      owner_next = bus.data_wr ? OWN_DATA_WR : OWN_DATA_RD;
    end else if (grant_i) begin
      owner_next = OWN_INST;
    end

    if (grant_i || !bus.inst_req) begin
      starve_cnt_next = 3'd0;
    end else if (grant_d && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_next = starve_cnt_reg + 3'd1;
    end
  end

  always_comb begin
    bus.inst_addr_ok = grant_i;
    bus.data_addr_ok = grant_d;
    bus.sram_en      = grant_i | grant_d;
    bus.sram_wen     = (grant_d && bus.data_wr) ? bus.data_wstrb : 4'd0;
    bus.sram_addr    = 32'd0;
    bus.sram_wdata   = 32'd0;
    if (reset) begin
      bus.sram_addr  = grant_d ? bus.data_addr : bus.inst_addr;
      bus.sram_wdata = bus.data_wdata;
    end

    // owner_reg is NONE throughout reset, so the response side needs no extra gating.
    bus.inst_data_ok = (owner_reg == OWN_INST);
    bus.data_data_ok = (owner_reg == OWN_DATA_RD) || (owner_reg == OWN_DATA_WR);
    bus.inst_rdata   = (owner_reg == OWN_INST)    ? bus.sram_rdata : 32'd0;
    bus.data_rdata   = (owner_reg == OWN_DATA_RD) ? bus.sram_rdata : 32'd0;
  end

endmodule
